instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
- Decode stage of the 5-stage ARM pipeline, directly downstream of the instruction-fetch stage.
- Takes the fetched instruction instD and decodes it into control signals and an extended immediate.
- Reads operands from an internal 16x32 register file. R15 reads return a PC-derived value.
- Registers all of this into the ID/EX pipeline register. Detects load-use and taken-branch hazards and drives the fetch stage's PCWrite, InstWrite and nop controls.

Parameters:
- NOP_INST, 32'hE2844000, bubble encoding (ADD R4,R4,#0). The fetch stage injects the same word.
- REG_INIT, 32'h00000000, reset value of R0-R14.

Ports:
- clk  in  1  clock; all pipeline state updates on negedge.
- reset  in  1  asynchronous, active-low reset.
- instD  in  32  instruction from fetch stage.
- pcF  in  32  current fetch-stage PC (address of instD + 4).
- RegWriteW  in  1  write-back enable.
- WA3W  in  4  write-back register address.
- WD3W  in  32  write-back data.
- PCSrcE  in  1  taken branch resolved in EX.
- PCWrite  out  1  to fetch stage; 0 = hold PC.
- InstWrite  out  1  to fetch stage; 0 = hold instD.
- nop  out  1  to fetch stage; 1 = replace instD with bubble.
- RD1E, RD2E  out  32 each  registered operands (Rn, Rm/Rd).
- ExtImmE  out  32  registered extended immediate.
- RnE, RmE  out  4 each  registered source addresses, for forwarding.
- WriteAddrE  out  4  registered destination (Rd).
- RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, FlagWriteE  out  1 each  registered controls.
- ALUControlE  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV.
- CondE  out  4  registered condition field instD[31:28].

Behaviour:
Reset (reset=0, asynchronous)
- All ID/EX outputs are 0, except RD1E, RD2E and ExtImmE, which are also 0.
- R0-R14 = REG_INIT.
- Hazard outputs while in reset: PCWrite=1, InstWrite=1, nop=0.

Decode (combinational from instD; op = instD[27:26])
- op=00, data-processing. cmd = instD[24:21]: ADD=0100, SUB=0010, AND=0000, ORR=1100, MOV=1101, CMP=1010 (ALU SUB, RegWrite=0).
  - FlagWrite = instD[20].
  - I=instD[25]=1: ALUSrc=1, ExtImm = {24'b0, imm8} rotated right by 2*instD[11:8].
  - I=0: ALUSrc=0, Rm = instD[3:0], shift field ignored.
  - Any other cmd: decoded as bubble (all enables 0).
- op=01, LDR/STR. instD[20]=1 gives LDR (RegWrite=1, MemtoReg=1); 0 gives STR (MemWrite=1, RD2 read from Rd).
  - ExtImm = zero-extended imm12. ALU ADD when U=instD[23]=1, else SUB. ALUSrc=1.
- op=10, B. Branch=1, ExtImm = sign-extended imm24 << 2, no register writes.
- op=11: bubble.

Register file
- Write on posedge clk when RegWriteW=1 and WA3W != 15; a write with WA3W=15 is ignored.
- Reads are combinational and see a same-cycle posedge write (write-first in the first half cycle).
- Reading address 15 returns pcF + 4, i.e. instruction address + 8.

Hazards (combinational)
- loaduse = MemtoRegE & (WriteAddrE == Rn(instD) | WriteAddrE == Rm/Rd source used by instD).
- loaduse=1: PCWrite=0, InstWrite=0, ID/EX loaded with a bubble (all enables 0), instD held.
- PCSrcE=1: nop=1, ID/EX loaded with a bubble; PCWrite stays 1.
- Both loaduse and PCSrcE: flush wins. PCWrite=1, InstWrite=1, nop=1, bubble.
- Branch latency: the branch resolves in EX, so 2 slots are flushed. The fetch stage covers one; this stage's bubble covers the other.

ID/EX register
- Updates every negedge clk when reset=1; there is no enable, stalls are inserted as bubbles.
- Latency from instD to the E outputs: 1 negedge.

Test Plan:
- Reset with reset=0 mid-run at an arbitrary time -> all E outputs 0 immediately; PCWrite=1, nop=0; R3 reads 0 after release.
- Write back R2=0x55 via RegWriteW, then decode instD=0xE0823002 (ADD R3,R2,R2) -> next negedge RD1E=RD2E=0x55, ALUControlE=000, WriteAddrE=3, RegWriteE=1.
- Decode instD=0xE3A010FF (MOV R1,#0xFF) -> ExtImmE=0x000000FF, ALUSrcE=1, ALUControlE=100.
- Decode instD=0xE28F0000 with pcF=0x100 -> RD1E=0x104.
- Set MemtoRegE=1, WriteAddrE=2, instD=ADD R3,R2,R2 -> PCWrite=0, InstWrite=0, next E outputs all enables 0. Drop MemtoRegE -> the ADD issues.
- Decode instD=0xEAFFFFFE -> ExtImmE=0xFFFFFFF8, BranchE=1. Then PCSrcE=1 together with a load-use condition -> nop=1, PCWrite=1, bubble registered.

Source files
------------

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - ARM pipeline decode stage: decode, register file, hazard unit, ID/EX register
module instruction_decode_stage #(
    parameter logic [31:0] NOP_INST = 32'hE2844000,
    parameter logic [31:0] REG_INIT = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instD,
    input  logic [31:0] pcF,
    input  logic        RegWriteW,
    input  logic [3:0]  WA3W,
    input  logic [31:0] WD3W,
    input  logic        PCSrcE,
    output logic        PCWrite,
    output logic        InstWrite,
    output logic        nop,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ExtImmE,
    output logic [3:0]  RnE,
    output logic [3:0]  RmE,
    output logic [3:0]  WriteAddrE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        MemtoRegE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        FlagWriteE,
    output logic [2:0]  ALUControlE,
    output logic [3:0]  CondE
);

    logic [31:0] r_rf [0:15];

    logic [1:0]  w_op;
    logic [3:0]  w_rn, w_rd, w_rm, w_ra1, w_ra2;
    logic [4:0]  w_rot;
    logic [31:0] w_imm32, w_rot_imm, w_ext_imm, w_rd1, w_rd2;
    logic        w_reg_write, w_mem_write, w_memto_reg, w_alu_src, w_branch, w_flag_write;
    logic [2:0]  w_alu_ctrl;
    logic        w_use_rn, w_use_ra2, w_loaduse, w_bubble;

    assign w_op      = instD[27:26];
    assign w_rn      = instD[19:16];
    assign w_rd      = instD[15:12];
    assign w_rm      = instD[3:0];
    assign w_rot     = {instD[11:8], 1'b0};
    assign w_imm32   = {24'b0, instD[7:0]};
    assign w_rot_imm = (w_imm32 >> w_rot) | (w_imm32 << (6'd32 - {1'b0, w_rot}));

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_memto_reg  = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_flag_write = 1'b0;
        w_alu_ctrl   = 3'b000;
        w_ext_imm    = 32'b0;
        w_ra1        = w_rn;
        w_ra2        = w_rm;
        w_use_rn     = 1'b0;
        w_use_ra2    = 1'b0;
        case (w_op)
            2'b00: begin
                w_use_rn     = 1'b1;
                w_use_ra2    = ~instD[25];
                w_alu_src    = instD[25];
                w_ext_imm    = instD[25] ? w_rot_imm : 32'b0;
                w_reg_write  = 1'b1;
                w_flag_write = instD[20];
                case (instD[24:21])
                    4'b0100: w_alu_ctrl = 3'b000;
                    4'b0010: w_alu_ctrl = 3'b001;
                    4'b0000: w_alu_ctrl = 3'b010;
                    4'b1100: w_alu_ctrl = 3'b011;
                    4'b1101: w_alu_ctrl = 3'b100;
                    4'b1010: begin
                        w_alu_ctrl  = 3'b001;
                        w_reg_write = 1'b0;
                    end
                    default: begin
                        w_reg_write  = 1'b0;
                        w_flag_write = 1'b0;
                        w_use_rn     = 1'b0;
                        w_use_ra2    = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_use_rn   = 1'b1;
                w_use_ra2  = ~instD[20];
                w_ra2      = w_rd;
                w_alu_src  = 1'b1;
                w_ext_imm  = {20'b0, instD[11:0]};
                w_alu_ctrl = instD[23] ? 3'b000 : 3'b001;
                if (instD[20]) begin
                    w_reg_write = 1'b1;
                    w_memto_reg = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
            end
            2'b10: begin
                // Branch target is computed in EX as PC + offset, so operand A is R15.
                w_branch  = 1'b1;
                w_ra1     = 4'd15;
                w_alu_src = 1'b1;
                w_ext_imm = {{6{instD[23]}}, instD[23:0], 2'b00};
            end
            default: ;
        endcase
        if (instD == NOP_INST) begin
            w_reg_write  = 1'b0;
            w_flag_write = 1'b0;
            w_use_rn     = 1'b0;
            w_use_ra2    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= REG_INIT;
        end else if (RegWriteW && (WA3W != 4'd15)) begin
            r_rf[WA3W] <= WD3W;
        end
    end

    assign w_rd1 = (w_ra1 == 4'd15) ? pcF + 32'd4 : r_rf[w_ra1];
    assign w_rd2 = (w_ra2 == 4'd15) ? pcF + 32'd4 : r_rf[w_ra2];

    assign w_loaduse = MemtoRegE & ((w_use_rn  & (WriteAddrE == w_rn)) |
                                    (w_use_ra2 & (WriteAddrE == w_ra2)));
    assign w_bubble  = w_loaduse | PCSrcE;
    // A flush discards the stalled instruction anyway, so it overrides the stall.
    assign PCWrite   = ~reset | PCSrcE | ~w_loaduse;
    assign InstWrite = ~reset | PCSrcE | ~w_loaduse;
    assign nop       = reset & PCSrcE;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            RD1E        <= 32'b0;
            RD2E        <= 32'b0;
            ExtImmE     <= 32'b0;
            RnE         <= 4'b0;
            RmE         <= 4'b0;
            WriteAddrE  <= 4'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            BranchE     <= 1'b0;
            FlagWriteE  <= 1'b0;
            ALUControlE <= 3'b0;
            CondE       <= 4'b0;
        end else begin
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ExtImmE     <= w_ext_imm;
            RnE         <= w_ra1;
            RmE         <= w_ra2;
            WriteAddrE  <= w_rd;
            RegWriteE   <= w_reg_write & ~w_bubble;
            MemWriteE   <= w_mem_write & ~w_bubble;
            MemtoRegE   <= w_memto_reg & ~w_bubble;
            ALUSrcE     <= w_alu_src;
            BranchE     <= w_branch & ~w_bubble;
            FlagWriteE  <= w_flag_write & ~w_bubble;
            ALUControlE <= w_alu_ctrl;
            CondE       <= instD[31:28];
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - directed self-checking bench for instruction_decode_stage
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instD, pcF, WD3W;
    logic        RegWriteW, PCSrcE;
    logic [3:0]  WA3W;
    logic        PCWrite, InstWrite, nop;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  RnE, RmE, WriteAddrE, CondE;
    logic        RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, FlagWriteE;
    logic [2:0]  ALUControlE;

    int errors = 0;
    int checks = 0;

    instruction_decode_stage dut (
        .clk(clk), .reset(reset), .instD(instD), .pcF(pcF),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .WD3W(WD3W), .PCSrcE(PCSrcE),
        .PCWrite(PCWrite), .InstWrite(InstWrite), .nop(nop),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RnE(RnE), .RmE(RmE), .WriteAddrE(WriteAddrE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
        .ALUControlE(ALUControlE), .CondE(CondE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; instD = 32'hE2844000; pcF = 32'h0;
        RegWriteW = 1'b0; WA3W = 4'd0; WD3W = 32'h0; PCSrcE = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_regwrite", {31'b0, RegWriteE}, 32'd0);
        chk("rst_rd1", RD1E, 32'h0);
        chk("rst_pcwrite", {29'b0, PCWrite, InstWrite, nop}, 32'b110);
        step(); step();
        reset = 1'b1;

        // ADD R3,R2,R2 with R2 written back in the same cycle
        RegWriteW = 1'b1; WA3W = 4'd2; WD3W = 32'h55; instD = 32'hE0823002;
        step();
        chk("add_rd1", RD1E, 32'h55);
        chk("add_rd2", RD2E, 32'h55);
        chk("add_alu", {29'b0, ALUControlE}, 32'd0);
        chk("add_wa", {28'b0, WriteAddrE}, 32'd3);
        chk("add_regwrite", {31'b0, RegWriteE}, 32'd1);
        chk("add_alusrc", {31'b0, ALUSrcE}, 32'd0);
        chk("add_cond", {28'b0, CondE}, 32'hE);

        // MOV R1,#0xFF while writing R3=0x77
        WA3W = 4'd3; WD3W = 32'h77; instD = 32'hE3A010FF;
        step();
        chk("mov_imm", ExtImmE, 32'h000000FF);
        chk("mov_alusrc", {31'b0, ALUSrcE}, 32'd1);
        chk("mov_alu", {29'b0, ALUControlE}, 32'd4);
        chk("mov_wa", {28'b0, WriteAddrE}, 32'd1);

        // ADD R0,PC,#0 with an ignored write to R15
        WA3W = 4'd15; WD3W = 32'hDEAD; instD = 32'hE28F0000; pcF = 32'h100;
        step();
        chk("pc_read", RD1E, 32'h104);
        RegWriteW = 1'b0;

        instD = 32'hE3A014FF;
        step();
        chk("rot_imm", ExtImmE, 32'hFF000000);

        // SUBS R1,R3,#1
        instD = 32'hE2531001;
        step();
        chk("subs_alu", {29'b0, ALUControlE}, 32'd1);
        chk("subs_flag", {31'b0, FlagWriteE}, 32'd1);
        chk("subs_rd1", RD1E, 32'h77);

        // CMP R3,#0x77
        instD = 32'hE3530077;
        step();
        chk("cmp_ctl", {29'b0, RegWriteE, FlagWriteE, ALUControlE == 3'b001}, 32'b011);

        // STR R3,[R2,#4]
        instD = 32'hE5823004;
        step();
        chk("str_ctl", {29'b0, MemWriteE, RegWriteE, MemtoRegE}, 32'b100);
        chk("str_rd2", RD2E, 32'h77);
        chk("str_imm", ExtImmE, 32'h4);

        // LDR R2,[R3,#-8]
        instD = 32'hE5132008;
        step();
        chk("ldr_ctl", {29'b0, RegWriteE, MemtoRegE, MemWriteE}, 32'b110);
        chk("ldr_alu", {29'b0, ALUControlE}, 32'd1);
        chk("ldr_imm", ExtImmE, 32'h8);
        chk("ldr_rd1", RD1E, 32'h77);

        // Load-use stall on ADD R3,R2,R2
        instD = 32'hE0823002;
        #1;
        chk("lu_stall", {29'b0, PCWrite, InstWrite, nop}, 32'b000);
        step();
        chk("lu_bubble", {27'b0, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlagWriteE}, 32'd0);
        chk("lu_release", {29'b0, PCWrite, InstWrite, nop}, 32'b110);
        step();
        chk("lu_issue_rw", {31'b0, RegWriteE}, 32'd1);
        chk("lu_issue_wa", {28'b0, WriteAddrE}, 32'd3);
        chk("lu_issue_rd1", RD1E, 32'h55);

        // ADD R4,R3,#2 after LDR R2: imm[3:0]=2 is not a register source
        instD = 32'hE5132008;
        step();
        instD = 32'hE2834002;
        #1;
        chk("lu_imm_nostall", {29'b0, PCWrite, InstWrite, nop}, 32'b110);

        // B . (offset -8)
        instD = 32'hEAFFFFFE;
        step();
        chk("b_imm", ExtImmE, 32'hFFFFFFF8);
        chk("b_branch", {30'b0, BranchE, RegWriteE}, 32'b10);

        // Flush coinciding with load-use
        instD = 32'hE5132008;
        step();
        instD = 32'hE0823002; PCSrcE = 1'b1;
        #1;
        chk("flush_hz", {29'b0, PCWrite, InstWrite, nop}, 32'b111);
        step();
        chk("flush_bubble", {27'b0, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlagWriteE}, 32'd0);
        PCSrcE = 1'b0;

        instD = 32'hEC000000;
        step();
        chk("op11_bubble", {27'b0, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlagWriteE}, 32'd0);
        instD = 32'hE2844000;
        step();
        chk("nop_bubble", {31'b0, RegWriteE}, 32'd0);

        // Asynchronous mid-run reset
        instD = 32'hE0823002;
        step();
        chk("pre_rst_rw", {31'b0, RegWriteE}, 32'd1);
        #2 reset = 1'b0; PCSrcE = 1'b1;
        #1;
        chk("mid_rst_ctl", {31'b0, RegWriteE}, 32'd0);
        chk("mid_rst_rd1", RD1E, 32'h0);
        chk("mid_rst_wa", {28'b0, WriteAddrE}, 32'd0);
        chk("mid_rst_hz", {29'b0, PCWrite, InstWrite, nop}, 32'b110);
        step();
        reset = 1'b1; PCSrcE = 1'b0;
        instD = 32'hE0830003;
        step();
        chk("post_rst_r3", RD1E, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
